// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (shift-add multiply, restoring divide)
// with a start/busy/valid handshake and fixed data_wl+2 cycle latency.
module alu_muldiv_seq #(
    parameter int unsigned          data_wl = 16,
    parameter int unsigned          op_wl   = 8,
    parameter logic [op_wl-1:0]     I_MUL   = 8'h02,
    parameter logic [op_wl-1:0]     I_SMUL  = 8'h22,
    parameter logic [op_wl-1:0]     I_MULH  = 8'h03,
    parameter logic [op_wl-1:0]     I_SMULH = 8'h23,
    parameter logic [op_wl-1:0]     I_DIV   = 8'h0F,
    parameter logic [op_wl-1:0]     I_SDIV  = 8'h2F,
    parameter logic [op_wl-1:0]     I_REM   = 8'h10,
    parameter logic [op_wl-1:0]     I_SREM  = 8'h30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [op_wl-1:0]   op_in,
    input  logic [data_wl-1:0] a_in,
    input  logic [data_wl-1:0] b_in,
    input  logic               c_flag_in,
    output logic [data_wl-1:0] c_out,
    output logic               z_flag_out,
    output logic               s_flag_out,
    output logic               c_flag_out,
    output logic               ovr_flag_out,
    output logic               busy,
    output logic               valid_out,
    output logic               op_active
);

    localparam int unsigned W     = data_wl;
    localparam int unsigned CNT_W = $clog2(data_wl);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [op_wl-1:0]   op_q, op_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       lo_q, lo_d;
    logic [W-1:0]       opnd_q, opnd_d;
    logic [W-1:0]       a_q, a_d;
    logic               neg_q, neg_d;
    logic               divz_q, divz_d;
    logic               sovf_q, sovf_d;
    logic [W-1:0]       c_q, c_d;
    logic               z_q, z_d, s_q, s_d, ovr_q, ovr_d;
    logic               busy_q, busy_d, valid_q, valid_d;

    logic               in_signed, in_mul, in_rem;
    logic [W-1:0]       a_mag, b_mag;
    logic               q_mul, q_hi, q_rem;
    logic [W:0]         mul_sum, div_shift, div_diff;
    logic [2*W-1:0]     prod, prod_s;
    logic [W-1:0]       quo, rem, res;

    assign op_active = (op_in == I_MUL)  || (op_in == I_SMUL) || (op_in == I_MULH) ||
                       (op_in == I_SMULH) || (op_in == I_DIV) || (op_in == I_SDIV) ||
                       (op_in == I_REM)  || (op_in == I_SREM);
    assign c_flag_out = c_flag_in;

    // Decode of the incoming request, used only on accept
    assign in_signed = (op_in == I_SMUL) || (op_in == I_SMULH) ||
                       (op_in == I_SDIV) || (op_in == I_SREM);
    assign in_mul    = (op_in == I_MUL) || (op_in == I_SMUL) ||
                       (op_in == I_MULH) || (op_in == I_SMULH);
    assign in_rem    = (op_in == I_REM) || (op_in == I_SREM);
    assign a_mag     = (in_signed && a_in[W-1]) ? -a_in : a_in;
    assign b_mag     = (in_signed && b_in[W-1]) ? -b_in : b_in;

    assign q_mul = (op_q == I_MUL) || (op_q == I_SMUL) || (op_q == I_MULH) || (op_q == I_SMULH);
    assign q_hi  = (op_q == I_MULH) || (op_q == I_SMULH);
    assign q_rem = (op_q == I_REM) || (op_q == I_SREM);

    // One iteration: multiply shifts {acc,lo} right, divide shifts {acc,lo} left
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q, lo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod   = {acc_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo_q : lo_q;
    assign rem    = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        neg_d   = neg_q;
        divz_d  = divz_q;
        sovf_d  = sovf_q;
        c_d     = c_q;
        z_d     = z_q;
        s_d     = s_q;
        ovr_d   = ovr_q;
        res     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && op_active) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = op_in;
                    a_d     = a_in;
                    acc_d   = '0;
                    lo_d    = in_mul ? b_mag : a_mag;
                    opnd_d  = in_mul ? a_mag : b_mag;
                    neg_d   = in_signed && (in_rem ? a_in[W-1] : (a_in[W-1] ^ b_in[W-1]));
                    divz_d  = (b_in == '0);
                    sovf_d  = ((op_in == I_SDIV) || (op_in == I_SREM)) &&
                              (a_in == {1'b1, {(W-1){1'b0}}}) && (b_in == '1);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (q_mul) begin
                    acc_d = mul_sum[W:1];
                    lo_d  = {mul_sum[0], lo_q[W-1:1]};
                end else if (!div_diff[W]) begin
                    acc_d = div_diff[W-1:0];
                    lo_d  = {lo_q[W-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[W-1:0];
                    lo_d  = {lo_q[W-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(data_wl - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (q_mul) begin
                    res = q_hi ? prod_s[2*W-1:W] : prod_s[W-1:0];
                    if (op_q == I_MUL)
                        ovr_d = |prod_s[2*W-1:W];
                    else if (op_q == I_SMUL)
                        ovr_d = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
                    else
                        ovr_d = 1'b0;
                end else if (divz_q) begin
                    res   = q_rem ? a_q : '1;
                    ovr_d = 1'b1;
                end else begin
                    // most-negative / -1 already yields MIN and 0 from the magnitude path
                    res   = q_rem ? rem : quo;
                    ovr_d = sovf_q;
                end
                c_d     = res;
                z_d     = (res == '0);
                s_d     = res[W-1];
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_RUN) || (state_d == S_FIX);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            divz_q  <= 1'b0;
            sovf_q  <= 1'b0;
            c_q     <= '0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            divz_q  <= divz_d;
            sovf_q  <= sovf_d;
            c_q     <= c_d;
            z_q     <= z_d;
            s_q     <= s_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign c_out        = c_q;
    assign z_flag_out   = z_q;
    assign s_flag_out   = s_q;
    assign ovr_flag_out = ovr_q;
    assign busy         = busy_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed plan cases, handshake/reset
// corner cases and random operations against an integer-arithmetic model.
module tb_alu_muldiv_seq;

    localparam int unsigned DW = 16;

    localparam logic [7:0] I_MUL = 8'h02, I_SMUL = 8'h22, I_MULH = 8'h03, I_SMULH = 8'h23;
    localparam logic [7:0] I_DIV = 8'h0F, I_SDIV = 8'h2F, I_REM  = 8'h10, I_SREM  = 8'h30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    op_in = '0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          c_flag_in = 1'b0;
    logic [DW-1:0] c_out;
    logic          z_flag_out, s_flag_out, c_flag_out, ovr_flag_out;
    logic          busy, valid_out, op_active;

    alu_muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_in(op_in),
        .a_in(a_in), .b_in(b_in), .c_flag_in(c_flag_in),
        .c_out(c_out), .z_flag_out(z_flag_out), .s_flag_out(s_flag_out),
        .c_flag_out(c_flag_out), .ovr_flag_out(ovr_flag_out),
        .busy(busy), .valid_out(valid_out), .op_active(op_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] c;
        logic          z;
        logic          s;
        logic          ovr;
        int            acc_cyc;
    } exp_t;

    exp_t scb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic [DW-1:0] c, input logic ovr);
        exp_t e;
        e.c = c; e.z = (c == '0); e.s = c[DW-1]; e.ovr = ovr; e.acc_cyc = 0;
        return e;
    endfunction

    // Reference arithmetic on 64-bit integers
    function automatic exp_t model(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p, sp, sa, sbv, q, r;
        logic [DW-1:0] c;
        logic ovr;
        p   = longint'(a) * longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sp  = sa * sbv;
        c   = '0;
        ovr = 1'b0;
        case (op)
            I_MUL:   begin c = p[15:0];   ovr = (p[31:16] != 16'h0); end
            I_SMUL:  begin c = sp[15:0];  ovr = (sp > 32767) || (sp < -32768); end
            I_MULH:  c = p[31:16];
            I_SMULH: c = sp[31:16];
            I_DIV, I_REM: begin
                if (b == '0) begin c = (op == I_DIV) ? 16'hFFFF : a; ovr = 1'b1; end
                else c = (op == I_DIV) ? a / b : a % b;
            end
            default: begin
                if (b == '0) begin
                    c = (op == I_SDIV) ? 16'hFFFF : a; ovr = 1'b1;
                end else if (a == 16'h8000 && b == 16'hFFFF) begin
                    c = (op == I_SDIV) ? 16'h8000 : 16'h0000; ovr = 1'b1;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    c = (op == I_SDIV) ? q[15:0] : r[15:0];
                end
            end
        endcase
        return mk_exp(c, ovr);
    endfunction

    // Compare each completion against the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                if (scb.size() == 0) begin
                    check("spurious_valid", 32'(valid_out), 32'd0);
                end else begin
                    e = scb.pop_front();
                    check("c_out", 32'(c_out), 32'(e.c));
                    check("z_flag", 32'(z_flag_out), 32'(e.z));
                    check("s_flag", 32'(s_flag_out), 32'(e.s));
                    check("ovr_flag", 32'(ovr_flag_out), 32'(e.ovr));
                    check("latency", 32'(cyc - e.acc_cyc), 32'(DW + 2));
                    check("busy_at_valid", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Called at a negedge; waits for an accepting state, then presents one request
    task automatic issue(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input exp_t e);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) check("ready_timeout", 32'(busy), 32'd0);
        start = 1'b1; op_in = op; a_in = a; b_in = b;
        e.acc_cyc = cyc;
        scb.push_back(e);
        @(negedge clk);
        start = 1'b0; op_in = 8'($urandom); a_in = DW'($urandom); b_in = DW'($urandom);
    endtask

    task automatic issue_m(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        issue(op, a, b, model(op, a, b));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && scb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(scb.size()), 32'd0);
    endtask

    function automatic logic [DW-1:0] pick_operand();
        logic [DW-1:0] v [5];
        v[0] = 16'h0000; v[1] = 16'h0001; v[2] = 16'hFFFF; v[3] = 16'h8000; v[4] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return v[$urandom_range(0, 4)];
        return DW'($urandom);
    endfunction

    initial begin
        logic [7:0] ops [8];
        ops[0] = I_MUL; ops[1] = I_SMUL; ops[2] = I_MULH; ops[3] = I_SMULH;
        ops[4] = I_DIV; ops[5] = I_SDIV; ops[6] = I_REM;  ops[7] = I_SREM;

        repeat (3) @(negedge clk);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_flags", 32'({z_flag_out, s_flag_out, ovr_flag_out}), 32'd0);
        reset = 1'b0;

        c_flag_in = 1'b1; #1 check("c_flag_pass1", 32'(c_flag_out), 32'd1);
        c_flag_in = 1'b0; #1 check("c_flag_pass0", 32'(c_flag_out), 32'd0);
        op_in = I_SREM;   #1 check("op_active_srem", 32'(op_active), 32'd1);

        // Unsupported opcode is not accepted
        @(negedge clk);
        start = 1'b1; op_in = 8'h01; a_in = 16'd5; b_in = 16'd3;
        #1 check("op_active_01", 32'(op_active), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_bad_op", 32'(busy), 32'd0);

        issue(I_MUL,   16'd300,  16'd300, mk_exp(16'h5F90, 1'b1));
        issue(I_MULH,  16'd300,  16'd300, mk_exp(16'h0001, 1'b0));
        issue(I_SMUL,  16'hFFFD, 16'd5,   mk_exp(16'hFFF1, 1'b0));
        issue(I_SMULH, 16'hFFFD, 16'd5,   mk_exp(16'hFFFF, 1'b0));
        issue(I_SDIV,  16'hFFF9, 16'd2,   mk_exp(16'hFFFD, 1'b0));
        issue(I_SREM,  16'hFFF9, 16'd2,   mk_exp(16'hFFFF, 1'b0));
        issue(I_DIV,   16'd100,  16'd7,   mk_exp(16'd14,   1'b0));
        issue(I_REM,   16'd100,  16'd7,   mk_exp(16'd2,    1'b0));
        issue(I_DIV,   16'h1234, 16'h0,   mk_exp(16'hFFFF, 1'b1));
        issue(I_REM,   16'h1234, 16'h0,   mk_exp(16'h1234, 1'b1));
        issue(I_SDIV,  16'h8000, 16'hFFFF, mk_exp(16'h8000, 1'b1));
        issue(I_SREM,  16'h8000, 16'hFFFF, mk_exp(16'h0000, 1'b1));
        drain();

        // A start while busy must be ignored
        issue_m(I_MUL, 16'h0102, 16'h0304);
        repeat (4) @(negedge clk);
        start = 1'b1; op_in = I_DIV; a_in = 16'd9; b_in = 16'd2;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_run", 32'(busy), 32'd1);
        drain();
        repeat (25) @(negedge clk);

        // Start presented in the valid_out cycle is accepted
        issue_m(I_DIV, 16'd100, 16'd7);
        for (int i = 0; i < 40 && !valid_out; i++) @(negedge clk);
        check("b2b_valid_seen", 32'(valid_out), 32'd1);
        issue_m(I_REM, 16'd100, 16'd7);
        drain();

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        start = 1'b1; op_in = I_DIV; a_in = 16'd1000; b_in = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        check("abort_flags", 32'({z_flag_out, s_flag_out, ovr_flag_out}), 32'd0);
        check("abort_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        issue(I_MUL, 16'd7, 16'd9, mk_exp(16'd63, 1'b0));
        drain();

        for (int n = 0; n < 40; n++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 7)];
            issue_m(op, pick_operand(), pick_operand());
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
